// File: rtl/fsm_job_arbiter.sv
// fsm_job_arbiter: round-robin arbiter that shares one start/done worker
// among NREQ requesters. A winner is latched in IDLE, gets a one-cycle
// worker_start in LAUNCH, waits for worker_done in WAIT and is acknowledged
// in RELEASE. All outputs decode from registered state, owner and error flag.
// Optional watchdog: define FSM_ARB_WATCHDOG_EN to abort a job whose worker
// never reports done within TIMEOUT WAIT cycles (ack with err=1).
module fsm_job_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 200
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic                    err,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    worker_start,
    input  logic                    worker_ready,
    input  logic                    worker_done,
    output logic                    arb_busy
);

    localparam int IW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RELEASE
    } state_t;

    // Reject parameter values the round-robin or watchdog cannot support.
    if (NREQ < 2 || NREQ > 16 || TIMEOUT < 2) begin : g_bad_param
        $error("fsm_job_arbiter: NREQ must be 2..16 and TIMEOUT >= 2");
    end

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_q,  last_d;
    logic [IW-1:0] winner;

`ifdef FSM_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
`endif

    // Round-robin pick: first set request after the last served index, wrapping.
    always_comb begin
        int            idx_i;
        logic [IW-1:0] idx;
        logic          found;
        winner = last_q;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_i = (int'(last_q) + k) % NREQ;
            idx   = IW'(idx_i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Next-state logic for the job handshake.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
`ifdef FSM_ARB_WATCHDOG_EN
        wd_d    = wd_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req && worker_ready) begin
                    owner_d = winner;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // A done seen here is dropped; the worker has not yet seen start.
                state_d = S_WAIT;
`ifdef FSM_ARB_WATCHDOG_EN
                wd_d    = '0;
`endif
            end
            S_WAIT: begin
                if (worker_done) begin
                    state_d = S_RELEASE;
`ifdef FSM_ARB_WATCHDOG_EN
                    err_d   = 1'b0;
                end else if (wd_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_RELEASE;
                    err_d   = 1'b1;
                end else begin
                    wd_d    = wd_q + CW'(1);
`endif
                end
            end
            S_RELEASE: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= IW'(NREQ - 1);
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

`ifdef FSM_ARB_WATCHDOG_EN
    // Watchdog counter and timeout flag reported with the ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = (state_q == S_RELEASE) && err_q;
`else
    assign err = 1'b0;
`endif

    assign gnt          = (state_q != S_IDLE)    ? (ONE_HOT0 << owner_q) : '0;
    assign ack          = (state_q == S_RELEASE) ? (ONE_HOT0 << owner_q) : '0;
    assign owner        = owner_q;
    assign worker_start = (state_q == S_LAUNCH);
    assign arb_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_fsm_job_arbiter.sv
// Testbench for fsm_job_arbiter: a table of per-cycle vectors plus
// hand-written sequences for asynchronous reset and long/timed-out WAIT.
module tb_fsm_job_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic       err;
    logic [1:0] owner;
    logic       worker_start;
    logic       worker_ready;
    logic       worker_done;
    logic       arb_busy;

    int total = 0;
    int bad   = 0;

    fsm_job_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .gnt          (gnt),
        .ack          (ack),
        .err          (err),
        .owner        (owner),
        .worker_start (worker_start),
        .worker_ready (worker_ready),
        .worker_done  (worker_done),
        .arb_busy     (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic       done;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       start;
        logic       busy;
        logic [1:0] owner;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] r, input logic rd, input logic d,
                                input logic [3:0] g, input logic [3:0] a,
                                input logic s, input logic b, input logic [1:0] o);
        vec_t v;
        v.rst = 1'b0; v.req = r; v.rdy = rd; v.done = d;
        v.gnt = g; v.ack = a; v.start = s; v.busy = b; v.owner = o;
        return v;
    endfunction

    function automatic vec_t mk_rst();
        vec_t v;
        v = mk(4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);
        v.rst = 1'b1;
        return v;
    endfunction

    // One full job for owner k: LAUNCH, WAIT, WAIT, RELEASE (done), IDLE.
    task automatic add_job(input logic [3:0] r, input logic [1:0] k);
        logic [3:0] oh;
        oh = 4'b0001 << k;
        vecs.push_back(mk(r, 1'b1, 1'b0, oh, 4'b0000, 1'b1, 1'b1, k));
        vecs.push_back(mk(r, 1'b1, 1'b0, oh, 4'b0000, 1'b0, 1'b1, k));
        vecs.push_back(mk(r, 1'b1, 1'b0, oh, 4'b0000, 1'b0, 1'b1, k));
        vecs.push_back(mk(r, 1'b1, 1'b1, oh, oh,      1'b0, 1'b1, k));
        vecs.push_back(mk(r, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, k));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic [3:0] a,
                              input logic e, input logic s, input logic b, input logic [1:0] o);
        check({tag, " gnt"},   32'(gnt),          32'(g));
        check({tag, " ack"},   32'(ack),          32'(a));
        check({tag, " err"},   32'(err),          32'(e));
        check({tag, " start"}, 32'(worker_start), 32'(s));
        check({tag, " busy"},  32'(arb_busy),     32'(b));
        check({tag, " owner"}, 32'(owner),        32'(o));
    endtask

    initial begin
        rst_n        = 1'b0;
        req          = 4'b0000;
        worker_ready = 1'b0;
        worker_done  = 1'b0;

        // Single job for requester 0, done three cycles after start.
        vecs.push_back(mk(4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0));
        vecs.push_back(mk(4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0));
        vecs.push_back(mk(4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0));
        vecs.push_back(mk(4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b1, 2'd0));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0));
        // All four requesting: order 0,1,2,3,0.
        vecs.push_back(mk_rst());
        add_job(4'b1111, 2'd0);
        add_job(4'b1111, 2'd1);
        add_job(4'b1111, 2'd2);
        add_job(4'b1111, 2'd3);
        add_job(4'b1111, 2'd0);
        // Worker not ready for 5 cycles, then grant to 2; done during LAUNCH is dropped.
        vecs.push_back(mk_rst());
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0));
        vecs.push_back(mk(4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2));
        vecs.push_back(mk(4'b0100, 1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2));
        vecs.push_back(mk(4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2));
        vecs.push_back(mk(4'b0100, 1'b1, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b1, 2'd2));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2));
        // Requester 1 drops req mid-job; stray done in IDLE is ignored.
        vecs.push_back(mk_rst());
        vecs.push_back(mk(4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 4'b0010, 4'b0010, 1'b0, 1'b1, 2'd1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1));
        // After last=1, req=1011 picks 3, then wraps to 0.
        vecs.push_back(mk(4'b1011, 1'b1, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3));
        vecs.push_back(mk(4'b1011, 1'b1, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b1, 2'd3));
        vecs.push_back(mk(4'b1011, 1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0, 1'b1, 2'd3));
        vecs.push_back(mk(4'b1011, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3));
        vecs.push_back(mk(4'b1011, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0));
        vecs.push_back(mk(4'b1011, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0));
        vecs.push_back(mk(4'b1011, 1'b1, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b1, 2'd0));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            req          = vecs[i].req;
            worker_ready = vecs[i].rdy;
            worker_done  = vecs[i].done;
            if (vecs[i].rst) rst_n = 1'b0;
            tick();
            check_outs($sformatf("v%0d", i), vecs[i].gnt, vecs[i].ack, 1'b0,
                       vecs[i].start, vecs[i].busy, vecs[i].owner);
            rst_n = 1'b1;
        end

        // Asynchronous reset in the middle of WAIT.
        rst_n = 1'b0;
        tick();
        rst_n        = 1'b1;
        req          = 4'b0100;
        worker_ready = 1'b1;
        worker_done  = 1'b0;
        tick();
        tick();
        check_outs("pre_rst_wait", 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        worker_done = 1'b1;
        tick();
        check_outs("rst_hold", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        rst_n       = 1'b1;
        worker_done = 1'b0;
        req         = 4'b0101;
        tick();
        check_outs("post_rst_gnt", 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd0);

        // Worker never reports done.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 4'b0011;
        tick();
        check_outs("wd_launch", 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            check_outs($sformatf("wd_wait%0d", i), 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0);
        end
`ifdef FSM_ARB_WATCHDOG_EN
        tick();
        check_outs("wd_timeout", 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1, 2'd0);
        tick();
        check_outs("wd_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        check_outs("wd_next", 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd1);
`else
        for (int i = 0; i < 4 * TIMEOUT; i++) begin
            tick();
            check_outs($sformatf("hold_wait%0d", i), 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0);
        end
        worker_done = 1'b1;
        tick();
        check_outs("late_done", 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0);
        worker_done = 1'b0;
        tick();
        check_outs("late_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        check_outs("late_next", 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fsm_job_arbiter.md
# fsm_job_arbiter

Round-robin job arbiter that shares one start/done worker FSM among `NREQ` requesters. It sits between the requesting blocks and the worker's `start`/`done`/`ready` handshake. It grants one requester at a time, issues a single start pulse, waits for completion and returns a per-requester acknowledge. An optional watchdog aborts jobs whose worker never reports done.

## Interface

Parameters:
- `NREQ`, 4, number of requesters (2..16)
- `TIMEOUT`, 200, watchdog limit in WAIT cycles (≥2; used only with watchdog compiled in)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  NREQ  per-requester job request, level; held until matching `ack`
- `gnt`  out  NREQ  one-hot grant, high from LAUNCH through RELEASE
- `ack`  out  NREQ  one-cycle completion pulse to the owner
- `err`  out  1  one-cycle pulse coincident with `ack` when the job timed out
- `owner`  out  $clog2(NREQ)  index of current/last granted requester
- `worker_start`  out  1  one-cycle start pulse to worker
- `worker_ready`  in  1  worker idle indicator
- `worker_done`  in  1  worker completion, sampled only in WAIT
- `arb_busy`  out  1  high whenever state ≠ IDLE

## Operation

- Clock and reset: one clock `clk`; asynchronous active-low reset `rst_n`.
- States: IDLE, LAUNCH, WAIT, RELEASE. The state is registered; all outputs are decoded from registered state, owner and error flag.
- IDLE:
  - If `|req` and `worker_ready`=1, select a winner by round-robin, latch it into `owner`, and go to LAUNCH.
  - Otherwise stay in IDLE.
- Round-robin:
  - Search starts at `last+1` and wraps modulo `NREQ`; the first set `req` bit wins.
  - `last` updates to `owner` in RELEASE.
  - `last` resets to `NREQ-1`, so requester 0 has first priority after reset.
- LAUNCH: `worker_start`=1 for exactly this cycle; unconditionally go to WAIT.
- WAIT:
  - On `worker_done`=1, go to RELEASE with the error flag cleared.
  - `worker_done` in any other state is ignored.
- RELEASE:
  - `ack[owner]`=1 and `err`=error flag for this cycle only.
  - Then go to IDLE; `gnt` drops on entry to IDLE.
- `gnt` = one-hot(`owner`) in LAUNCH, WAIT and RELEASE; 0 in IDLE.
- `req` is ignored outside IDLE. Deasserting `req` mid-job does not abort the job; it still completes and is acked.
- A requester still asserting `req` after its `ack` is eligible again, but only after every other pending requester has been served once.
- Reset values: state IDLE, `gnt`=0, `ack`=0, `err`=0, `owner`=0, `last`=NREQ-1, `worker_start`=0, `arb_busy`=0.
- Reset asserted mid-job:
  - All outputs return to reset values immediately (asynchronous).
  - No `ack` is issued for the aborted job.

## Timing

- Grant latency: `req` and `worker_ready` high at edge N → `gnt` and `worker_start` high in cycle N+1.
- `worker_start` is exactly one cycle wide; WAIT begins at cycle N+2.
- Completion: `worker_done` sampled high at edge D → `ack` in cycle D+1 → IDLE in cycle D+2.
- Earliest next `worker_start` is cycle D+3.
- Back-to-back minimum job period is 4 cycles plus worker run time.
- `worker_done` arriving in the LAUNCH cycle is dropped. The worker's done must not precede its registered start response.

## Configuration

- Macro: `FSM_ARB_WATCHDOG_EN`.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches `TIMEOUT-1` with `worker_done`=0, go to RELEASE with the error flag set, giving `err`=1 alongside `ack`.
  - `worker_done` and timeout in the same cycle: done wins, `err`=0.
- Undefined:
  - No counter is built.
  - WAIT persists until `worker_done`.
  - `err` is tied to 0.
  - `TIMEOUT` is unused.

## Test plan

- Reset then `req`=4'b0001, `worker_ready`=1: `gnt`=0001 and `worker_start` pulse in cycle 1. Drive `worker_done` 3 cycles later → `ack`=0001 one cycle, `err`=0, `owner`=0.
- `req`=4'b1111 held, worker completes each job after 2 cycles: grant order 0,1,2,3,0. Exactly one `worker_start` per grant, `gnt` always one-hot.
- `req`=4'b0100 while `worker_ready`=0 for 5 cycles: no grant and `arb_busy`=0. `worker_ready`→1 → grant to 2 the next cycle.
- Watchdog built, `TIMEOUT`=8, no `worker_done`: `ack` plus `err`=1 eight cycles after WAIT entry, then the next requester is granted. Without the macro: stays in WAIT indefinitely, `err` never asserts.
- `rst_n` pulled low during WAIT: `gnt`, `worker_start` and `arb_busy` clear immediately, no `ack`. After release, requester 0 wins first.
- Requester 1 drops `req` mid-job and `worker_done` pulses during IDLE: the job still acks requester 1, and the stray done causes no state change.
